display_scan: RTL

Four-digit multiplexed 7-segment display driver that sits directly downstream of the CPU's four 8-bit output ports. It captures port values on an update strobe into shadow registers and commits them to the visible set only at frame boundaries, so a digit never tears mid-scan. It then time-multiplexes the four digits onto one shared segment bus.

---
 rtl/display_pkg.sv | 27 ++
 rtl/display_scan_seg_font.sv | 13 +
 rtl/display_scan.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit multiplexed 7-segment driver.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
package display_pkg;

  localparam int NDIG = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyphs, bit SEG_A is the LSB; entry index is the nibble value.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    OFF  = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/display_scan_seg_font.sv
// Combinational nibble-to-segment lookup for one hex digit (segments a..g).
module seg_font
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = FONT[nib];
  end

endmodule

// File: rtl/display_scan.sv
// Tear-free four-digit 7-segment scanner: shadow registers commit at frame boundaries.
// Define DISPLAY_SCAN_LZB_EN to blank leading zero digits (digit 0 always shown).
module display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic       upd,
  input  logic       blank,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  state_e           state_q, state_d;
  logic [7:0]       act_q [NDIG];
  logic [7:0]       act_d [NDIG];
  logic [7:0]       sh_q  [NDIG];
  logic [7:0]       sh_d  [NDIG];
  logic [7:0]       din   [NDIG];
  logic             pending_q, pending_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             boundary;
  logic             commit;
  logic [3:0]       nib;
  logic             dp;
  logic [6:0]       font_seg;
  logic [NDIG-1:0]  lz_mask;

  assign din = '{d0, d1, d2, d3};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    state_d   = state_q;
    act_d     = act_q;
    sh_d      = sh_q;
    pending_d = pending_q;

    tick     = (cnt_q == DIV_W'(SCAN_DIV - 1));
    boundary = tick && (state_q == SCAN) && (idx_q == 2'd3);
    // Entering SCAN also starts a frame, so pending data is taken then (without a pulse).
    commit   = boundary || (tick && (state_q == OFF));

    if (tick) begin
      cnt_d   = '0;
      state_d = SCAN;
      idx_d   = (state_q == SCAN) ? idx_q + 2'd1 : 2'd0;
    end

    if (commit && upd) begin
      act_d     = din;
      sh_d      = din;
      pending_d = 1'b0;
    end else if (commit && pending_q) begin
      act_d     = sh_q;
      pending_d = 1'b0;
    end else if (upd) begin
      sh_d      = din;
      pending_d = 1'b1;
    end

    frame_d = boundary;
  end

  assign nib = act_d[idx_d][3:0];
  assign dp  = act_d[idx_d][SEG_DP];

  seg_font u_font (
    .nib (nib),
    .seg (font_seg)
  );

`ifdef DISPLAY_SCAN_LZB_EN
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      run        = run && (act_d[i][3:0] == 4'h0) && !act_d[i][SEG_DP];
      lz_mask[i] = run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Outputs track the post-edge idx/act every cycle; those only move on ticks,
  // so this holds between ticks and also restores the digit right after blank.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 8'h00;
    if (!blank && (state_d == SCAN)) begin
      an_d = ~(4'b0001 << idx_d);
      if (!lz_mask[idx_d]) begin
        seg_d = {dp, font_seg};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      state_q   <= OFF;
      act_q     <= '{default: '0};
      sh_q      <= '{default: '0};
      pending_q <= 1'b0;
      seg_q     <= 8'h00;
      an_q      <= 4'b1111;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      act_q     <= act_d;
      sh_q      <= sh_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
